regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 127 ++++++++++++
 tb/tb_regfile_mp.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: DEPTH x DATA_W register file with two combinational read ports,
// one write port, and a self-sequenced clear that zeroes one entry per cycle.
// The clear runs after reset and on clr_req. Writes arriving during a clear are
// discarded and flagged on wr_drop.
// Ports: clk/rst (async, active-high); raddr1/rdata1, raddr2/rdata2 read ports;
//        we/waddr/wdata write port; clr_req starts a clear; busy is high while
//        clearing; wr_drop is a one-cycle pulse marking a discarded write.
// Optional macro REGFILE_BYPASS_EN forwards wdata to a read port whose address
// matches waddr in the same cycle.
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Single write path into the array, shared by user writes and the clear walk.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic busy_w;
  assign busy_w  = (state_q == CLEAR);
  assign busy    = busy_w;
  assign wr_drop = wr_drop_q;

  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
    return (R0_ZERO != 0) && (a == '0);
  endfunction

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          // A write colliding with the clear request loses: it is dropped.
          state_d   = CLEAR;
          ptr_d     = '0;
          wr_drop_d = we;
        end else if (we && !is_zero_addr(waddr)) begin
          mem_we = 1'b1;
        end
      end
      CLEAR: begin
        // clr_req is deliberately ignored here: no restart, no extension.
        wr_drop_d = we;
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        if (ptr_q == '1) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Array contents are not reset; the clear walk that follows reset zeroes them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read priority (lowest to highest): stored value, forwarded write data,
  // forced zero for hard-wired entry 0 or an active clear.
  always_comb begin
    rdata1 = mem_q[raddr1];
`ifdef REGFILE_BYPASS_EN
    if (we && (waddr == raddr1)) rdata1 = wdata;
`endif
    if (busy_w || is_zero_addr(raddr1)) rdata1 = '0;
  end

  always_comb begin
    rdata2 = mem_q[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (we && (waddr == raddr2)) rdata2 = wdata;
`endif
    if (busy_w || is_zero_addr(raddr2)) rdata2 = '0;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  localparam int SIG_RD1  = 0;
  localparam int SIG_RD2  = 1;
  localparam int SIG_BUSY = 2;
  localparam int SIG_DROP = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] raddr1, raddr2, waddr;
  logic [DATA_W-1:0] rdata1, rdata2, wdata;
  logic              we, clr_req, busy, wr_drop;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .R0_ZERO(1)) dut (
    .clk(clk), .rst(rst),
    .raddr1(raddr1), .rdata1(rdata1),
    .raddr2(raddr2), .rdata2(rdata2),
    .we(we), .waddr(waddr), .wdata(wdata),
    .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic expect_v(input int sig, input logic [31:0] v, input string nm);
    exp_t e;
    e.sig = sig; e.exp = v; e.name = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: samples mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sig)
        SIG_RD1:  act = rdata1;
        SIG_RD2:  act = rdata2;
        SIG_BUSY: act = {31'd0, busy};
        default:  act = {31'd0, wr_drop};
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect busy=1 for exactly DEPTH cycles starting in the current cycle,
  // then busy=0 in the cycle after.
  task automatic check_clear_window(input string nm);
    for (int w = 0; w < DEPTH; w++) begin
      expect_v(SIG_BUSY, 32'd1, nm);
      tick();
    end
    expect_v(SIG_BUSY, 32'd0, {nm, "_end"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; we = 1'b0; clr_req = 1'b0;
    raddr1 = '0; raddr2 = '0; waddr = '0; wdata = '0;
    #1;
    expect_v(SIG_BUSY, 32'd1, "rst_busy");
    expect_v(SIG_DROP, 32'd0, "rst_drop");
    tick();
    tick();
    rst = 1'b0;

    // Reset release: 32 busy cycles, then every entry reads zero.
    raddr1 = 5'd9;
    expect_v(SIG_RD1, 32'h0, "rd_busy_zero");
    check_clear_window("rst_clear");
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      raddr1 = ADDR_W'(a);
      raddr2 = ADDR_W'(DEPTH - 1 - a);
      expect_v(SIG_RD1, 32'h0, "init_rd1");
      expect_v(SIG_RD2, 32'h0, "init_rd2");
      tick();
    end

    // Write then read on both ports.
    raddr1 = '0; raddr2 = '0;
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
    expect_v(SIG_RD1, 32'hDEADBEEF, "wr_rd1");
    expect_v(SIG_RD2, 32'hDEADBEEF, "wr_rd2");
    expect_v(SIG_DROP, 32'd0, "wr_nodrop");
    tick();

    // Hard-wired zero entry: write ignored, no drop pulse.
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr1 = 5'd0; raddr2 = 5'd0;
    expect_v(SIG_RD1, 32'h0, "r0_same_cyc");
    tick();
    we = 1'b0;
    expect_v(SIG_RD1, 32'h0, "r0_rd1");
    expect_v(SIG_RD2, 32'h0, "r0_rd2");
    expect_v(SIG_DROP, 32'd0, "r0_nodrop");
    tick();

    // Bypass: entry 7 holds 1, then write 0xA5A5A5A5 while reading 7.
    we = 1'b1; waddr = 5'd7; wdata = 32'h1; raddr1 = 5'd5;
    tick();
    waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr1 = 5'd7; raddr2 = 5'd5;
`ifdef REGFILE_BYPASS_EN
    expect_v(SIG_RD1, 32'hA5A5A5A5, "bypass_rd1");
`else
    expect_v(SIG_RD1, 32'h1, "nobypass_rd1");
`endif
    expect_v(SIG_RD2, 32'hDEADBEEF, "bypass_rd2_other");
    tick();
    we = 1'b0;
    expect_v(SIG_RD1, 32'hA5A5A5A5, "after_wr_rd1");
    tick();

    // Entry 3 gets 0x55 ahead of the clear collision.
    we = 1'b1; waddr = 5'd3; wdata = 32'h55;
    tick();
    we = 1'b0; raddr1 = 5'd3;
    expect_v(SIG_RD1, 32'h55, "e3_preload");
    tick();

    // Clear collision: clr_req with a write to 3 in the same idle cycle.
    clr_req = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF; raddr1 = 5'd9;
    expect_v(SIG_BUSY, 32'd0, "coll_idle");
    tick();
    raddr1 = 5'd7; raddr2 = 5'd3;
    for (int w = 1; w <= DEPTH; w++) begin
      clr_req = (w == 10);
      we      = (w == 5);
      waddr   = 5'd2;
      wdata   = 32'h77;
      expect_v(SIG_BUSY, 32'd1, "coll_busy");
      if (w == 1) expect_v(SIG_DROP, 32'd1, "coll_drop");
      if (w == 2) expect_v(SIG_DROP, 32'd0, "coll_drop_1cyc");
      if (w == 3) expect_v(SIG_RD1, 32'h0, "busy_rd1_zero");
      if (w == 6) expect_v(SIG_DROP, 32'd1, "busy_wr_drop");
      if (w == 7) expect_v(SIG_DROP, 32'd0, "busy_wr_drop_1cyc");
      if (w == 20) expect_v(SIG_RD2, 32'h0, "busy_rd2_zero");
      tick();
    end
    clr_req = 1'b0; we = 1'b0;
    expect_v(SIG_BUSY, 32'd0, "coll_no_extend");
    expect_v(SIG_RD1, 32'h0, "coll_e7_cleared");
    expect_v(SIG_RD2, 32'h0, "coll_e3_cleared");
    tick();
    raddr1 = 5'd2; raddr2 = 5'd5;
    expect_v(SIG_RD1, 32'h0, "busy_wr_discarded");
    expect_v(SIG_RD2, 32'h0, "coll_e5_cleared");
    tick();

    // Reset in the middle of a clear restarts the full walk.
    we = 1'b1; waddr = 5'd30; wdata = 32'h99;
    tick();
    we = 1'b0; raddr1 = 5'd30;
    expect_v(SIG_RD1, 32'h99, "e30_preload");
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int w = 1; w < 15; w++) tick();
    rst = 1'b1;
    expect_v(SIG_BUSY, 32'd1, "midrst_busy");
    tick();
    expect_v(SIG_DROP, 32'd0, "midrst_drop");
    tick();
    rst = 1'b0;
    check_clear_window("midrst_clear");
    raddr1 = 5'd30; raddr2 = 5'd31;
    tick();
    expect_v(SIG_RD1, 32'h0, "midrst_e30");
    expect_v(SIG_RD2, 32'h0, "midrst_e31");
    tick();

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
